// File: rtl/imem_stream_loader_pkg.sv
// Shared types and frame-field widths for the imem stream loader.
// The FSM state enum, the default sync marker and the lane/word geometry live here.
package loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_LO,
      S_CNT_HI,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned WORD_W        = 32;
   localparam int unsigned CNT_W         = 16;
   localparam int unsigned LANE_W        = 2;

   // States in which the inter-byte idle timer is armed.
   function automatic logic timed_state(input state_t s);
      return (s == S_CNT_LO) || (s == S_CNT_HI) || (s == S_DATA) || (s == S_CSUM);
   endfunction

endpackage

// File: rtl/imem_stream_loader_if.sv
// Byte-stream input, imem write port and status bundle of the loader.
// master = stream source / observer side, slave = the loader itself.
interface imem_stream_loader_if #(
   parameter int unsigned ADDR_W = 8
) ();

   logic [loader_pkg::BYTE_W-1:0] in_data;
   logic                          in_valid;
   logic                          in_ready;
   logic                          restart;
   logic                          imem_we;
   logic [ADDR_W-1:0]             imem_addr;
   logic [loader_pkg::WORD_W-1:0] imem_wdata;
   logic                          cpu_hold;
   logic                          done;
   logic                          err;

   modport master (
      output in_data, in_valid, restart,
      input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
   );

   modport slave (
      input  in_data, in_valid, restart,
      output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
   );

endinterface

// File: rtl/imem_stream_loader_word_assembler.sv
// Little-endian byte-lane shifter: collects four bytes into one 32-bit word.
// The word is presented combinationally together with the 4th byte.
module word_assembler
   import loader_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              byte_valid_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic              word_valid_o,
   output logic [WORD_W-1:0] word_o
);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [23:0]       low_q, low_d;

   always_comb begin
      lane_d = lane_q;
      low_d  = low_q;
      if (clear_i) begin
         lane_d = '0;
         low_d  = '0;
      end else if (byte_valid_i) begin
         lane_d = lane_q + 2'd1;
         case (lane_q)
            2'd0:    low_d[7:0]   = byte_i;
            2'd1:    low_d[15:8]  = byte_i;
            2'd2:    low_d[23:16] = byte_i;
            default: low_d        = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lane_q <= '0;
         low_q  <= '0;
      end else begin
         lane_q <= lane_d;
         low_q  <= low_d;
      end
   end

   assign word_valid_o = byte_valid_i && !clear_i && (lane_q == 2'd3);
   assign word_o       = {byte_i, low_q};

endmodule

// File: rtl/imem_stream_loader.sv
// Loads a framed program image into instruction memory and holds the core in
// reset until the payload checksum matches.
module imem_stream_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   imem_stream_loader_if.slave  bus
);

   localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W:0]   DEPTH    = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;

   state_t              state_q;
   logic                in_ready_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [WORD_W-1:0]   wdata_q;
   logic                hold_q;
   logic                done_q;
   logic                err_q;
   logic [BYTE_W-1:0]   n_lo_q;
   logic [CNT_W-1:0]    n_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [BYTE_W-1:0]   xor_q;
   logic [TMR_W-1:0]    tmr_q;

   logic                transfer;
   logic                word_valid;
   logic [WORD_W-1:0]   word;

   assign transfer = bus.in_valid && in_ready_q;

   // Lanes are held clear outside DATA, so any abort discards a partial word.
   word_assembler u_asm (
      .clk_i        (clk),
      .rst_ni       (reset),
      .clear_i      (state_q != S_DATA),
      .byte_valid_i (transfer && (state_q == S_DATA)),
      .byte_i       (bus.in_data),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         n_lo_q     <= '0;
         n_q        <= '0;
         cnt_q      <= '0;
         xor_q      <= '0;
         tmr_q      <= '0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               in_ready_q <= 1'b1;
               if (transfer && (bus.in_data == SYNC_BYTE)) begin
                  state_q <= S_CNT_LO;
                  cnt_q   <= '0;
                  xor_q   <= '0;
                  tmr_q   <= '0;
               end
            end
            S_CNT_LO: if (transfer) begin
               n_lo_q  <= bus.in_data;
               state_q <= S_CNT_HI;
            end
            S_CNT_HI: if (transfer) begin
               n_q <= {bus.in_data, n_lo_q};
               if ({1'b0, bus.in_data, n_lo_q} > DEPTH) begin
                  state_q    <= S_ERR;
                  err_q      <= 1'b1;
                  in_ready_q <= 1'b0;
               end else if ({bus.in_data, n_lo_q} == '0) begin
                  state_q <= S_CSUM;
               end else begin
                  state_q <= S_DATA;
               end
            end
            S_DATA: if (transfer) begin
               xor_q <= xor_q ^ bus.in_data;
               if (word_valid) begin
                  we_q    <= 1'b1;
                  addr_q  <= cnt_q[ADDR_W-1:0];
                  wdata_q <= word;
                  cnt_q   <= cnt_q + 1'b1;
                  if (cnt_q == n_q - 1'b1) state_q <= S_CSUM;
               end
            end
            S_CSUM: if (transfer) begin
               in_ready_q <= 1'b0;
               if (bus.in_data == xor_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  hold_q  <= 1'b0;
               end else begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
               end
            end
            S_DONE, S_ERR: if (bus.restart) begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b1;
               done_q     <= 1'b0;
               err_q      <= 1'b0;
               hold_q     <= 1'b1;
               n_lo_q     <= '0;
               n_q        <= '0;
               cnt_q      <= '0;
               xor_q      <= '0;
               tmr_q      <= '0;
            end
            default: state_q <= S_IDLE;
         endcase

         // Timeout can only fire on a cycle with no transfer, so it never
         // competes with the byte-driven transitions above.
         if (timed_state(state_q)) begin
            if (transfer) begin
               tmr_q <= '0;
            end else if (tmr_q == TMR_LAST) begin
               state_q    <= S_ERR;
               err_q      <= 1'b1;
               in_ready_q <= 1'b0;
               tmr_q      <= '0;
            end else begin
               tmr_q <= tmr_q + 1'b1;
            end
         end
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.cpu_hold   = hold_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: directed frame table, random
// frames against a frame-parsing reference model, and multi-cycle corner cases.
module tb_imem_stream_loader;

   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned TMO   = 32;
   localparam logic [7:0]  SYNC  = 8'hA5;

   localparam int ST_NONE = 0;
   localparam int ST_DONE = 1;
   localparam int ST_ERR  = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   imem_stream_loader_if #(.ADDR_W(AW)) bus ();

   imem_stream_loader #(
      .ADDR_W      (AW),
      .SYNC_BYTE   (SYNC),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int nvec = 0;
   int nmis = 0;

   logic [AW-1:0] got_addr[$];
   logic [31:0]   got_data[$];
   logic [7:0]    stim_q[$];
   logic [31:0]   exp_w_q[$];
   int            exp_status;

   typedef struct {
      logic [127:0] frame;   // right-aligned, first byte most significant
      int           len;
      logic         exp_done;
      logic         exp_err;
      int           exp_writes;
   } vec_t;
   vec_t tbl[6];

   always @(posedge clk) begin
      #2;
      if (bus.imem_we === 1'b1) begin
         got_addr.push_back(bus.imem_addr);
         got_data.push_back(bus.imem_wdata);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: parse the byte list as a frame using the framing rules directly.
   function automatic void run_model();
      int i = 0;
      int n;
      logic [7:0]  x = 8'h00;
      logic [31:0] w;
      exp_w_q.delete();
      exp_status = ST_NONE;
      while (i < stim_q.size() && stim_q[i] != SYNC) i++;
      if (i + 2 >= stim_q.size()) return;
      n = int'(stim_q[i+1]) + 256 * int'(stim_q[i+2]);
      i += 3;
      if (n > int'(DEPTH)) begin
         exp_status = ST_ERR;
         return;
      end
      for (int k = 0; k < n; k++) begin
         if (i + 4 > stim_q.size()) return;
         w = '0;
         for (int b = 0; b < 4; b++) begin
            w = w | (32'(stim_q[i+b]) << (8 * b));
            x = x ^ stim_q[i+b];
         end
         exp_w_q.push_back(w);
         i += 4;
      end
      if (i >= stim_q.size()) return;
      exp_status = (stim_q[i] == x) ? ST_DONE : ST_ERR;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int g;
      bit sent = 0;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
         bus.in_data = 8'($urandom);
         @(negedge clk);
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      for (int t = 0; t < 50 && !sent; t++) begin
         if (bus.in_ready) sent = 1;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      if (!sent) check("send_accept", 64'd0, 64'd1);
   endtask

   task automatic send_stim(input int max_gap);
      foreach (stim_q[i]) send_byte(stim_q[i], max_gap);
   endtask

   task automatic wait_outcome();
      bit seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
         if (bus.done || bus.err) seen = 1;
         else @(negedge clk);
      end
      if (!seen) check("outcome_timeout", 64'd0, 64'd1);
      @(negedge clk);
   endtask

   task automatic check_writes();
      check("write_count", 64'(got_addr.size()), 64'(exp_w_q.size()));
      for (int k = 0; k < got_addr.size() && k < exp_w_q.size(); k++) begin
         check("write_addr", 64'(got_addr[k]), 64'(k));
         check("write_data", 64'(got_data[k]), 64'(exp_w_q[k]));
      end
   endtask

   task automatic check_final(input logic d, input logic e);
      check("done", 64'(bus.done), 64'(d));
      check("err", 64'(bus.err), 64'(e));
      check("cpu_hold", 64'(bus.cpu_hold), 64'(!d));
      check("in_ready_final", 64'(bus.in_ready), 64'd0);
   endtask

   task automatic do_restart();
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      check("restart_done", 64'(bus.done), 64'd0);
      check("restart_err", 64'(bus.err), 64'd0);
      check("restart_hold", 64'(bus.cpu_hold), 64'd1);
      check("restart_ready", 64'(bus.in_ready), 64'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, "_imem_we"}, 64'(bus.imem_we), 64'd0);
      check({tag, "_imem_addr"}, 64'(bus.imem_addr), 64'd0);
      check({tag, "_imem_wdata"}, 64'(bus.imem_wdata), 64'd0);
      check({tag, "_cpu_hold"}, 64'(bus.cpu_hold), 64'd1);
      check({tag, "_done"}, 64'(bus.done), 64'd0);
      check({tag, "_err"}, 64'(bus.err), 64'd0);
   endtask

   initial begin
      logic [7:0] x;
      int n;

      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.restart  = 1'b0;

      // Good frame: payload XOR 13^93^10 is 0x90.
      tbl[0] = '{128'hA5_02_00_13_00_00_00_93_00_10_00_90, 12, 1'b1, 1'b0, 2};
      tbl[1] = '{128'hA5_02_00_13_00_00_00_93_00_10_00_81, 12, 1'b0, 1'b1, 2};
      tbl[2] = '{128'hA5_02_00_13_00_00_00_93_00_10_00_80, 12, 1'b0, 1'b1, 2};
      tbl[3] = '{128'h00_FF_A5_00_00_00, 6, 1'b1, 1'b0, 0};
      tbl[4] = '{128'hA5_11_00, 3, 1'b0, 1'b1, 0};
      tbl[5] = '{128'hA5_01_00_EF_BE_AD_DE_22, 8, 1'b1, 1'b0, 1};

      // Reset held low for two cycles, then released.
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b1;
      @(negedge clk);
      check("reset_ready_after", 64'(bus.in_ready), 64'd1);
      check("reset_hold_after", 64'(bus.cpu_hold), 64'd1);

      foreach (tbl[v]) begin
         stim_q.delete();
         for (int k = 0; k < tbl[v].len; k++)
            stim_q.push_back(tbl[v].frame[8*(tbl[v].len-1-k) +: 8]);
         run_model();
         got_addr.delete();
         got_data.delete();
         send_stim(0);
         wait_outcome();
         check_final(tbl[v].exp_done, tbl[v].exp_err);
         check("table_writes", 64'(got_addr.size()), 64'(tbl[v].exp_writes));
         check_writes();
         do_restart();
      end

      // Idle timeout after the first payload byte.
      got_addr.delete();
      got_data.delete();
      stim_q = '{8'hA5, 8'h01, 8'h00, 8'h13};
      send_stim(0);
      repeat (TMO - 1) @(negedge clk);
      check("timeout_early", 64'(bus.err), 64'd0);
      @(negedge clk);
      check("timeout_err", 64'(bus.err), 64'd1);
      check("timeout_hold", 64'(bus.cpu_hold), 64'd1);
      check("timeout_no_we", 64'(got_addr.size()), 64'd0);
      do_restart();

      // Reset mid-word, then the good frame with random stalls.
      stim_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
      send_stim(0);
      reset = 1'b0;
      @(negedge clk);
      check_reset_values("midreset");
      reset = 1'b1;
      @(negedge clk);
      check("midreset_no_we", 64'(got_addr.size()), 64'd0);
      check("midreset_ready", 64'(bus.in_ready), 64'd1);
      stim_q.delete();
      for (int k = 0; k < tbl[0].len; k++)
         stim_q.push_back(tbl[0].frame[8*(tbl[0].len-1-k) +: 8]);
      run_model();
      send_stim(3);
      wait_outcome();
      check_final(1'b1, 1'b0);
      check_writes();
      do_restart();

      // Random frames against the reference model.
      for (int r = 0; r < 24; r++) begin
         stim_q.delete();
         repeat ($urandom_range(3, 0)) begin
            x = 8'($urandom);
            stim_q.push_back((x == SYNC) ? 8'h00 : x);
         end
         n = ($urandom_range(5, 0) == 0) ? int'($urandom_range(DEPTH + 4, DEPTH + 1))
                                         : int'($urandom_range(DEPTH, 0));
         if (r == 0) n = DEPTH;
         stim_q.push_back(SYNC);
         stim_q.push_back(8'(n));
         stim_q.push_back(8'(n >> 8));
         if (n <= int'(DEPTH)) begin
            x = 8'h00;
            for (int k = 0; k < 4 * n; k++) begin
               stim_q.push_back(8'($urandom));
               x = x ^ stim_q[stim_q.size()-1];
            end
            if ($urandom_range(3, 0) == 0) x = x ^ 8'(1 << $urandom_range(7, 0));
            stim_q.push_back(x);
         end
         run_model();
         got_addr.delete();
         got_data.delete();
         send_stim(3);
         wait_outcome();
         check_final(exp_status == ST_DONE, exp_status == ST_ERR);
         check_writes();
         do_restart();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
